// File: rtl/writeback_stage_pkg.sv
// Shared constants for the writeback stage: opcodes, load funct3, CSR, FSM.
// Optional tohost CSR support is enabled with CSR_TOHOST_EN.
package writeback_stage_pkg;

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_ARI_ITYPE = 7'b0010011;
    localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0]  F3_CSRRW  = 3'b001;
    localparam logic [2:0]  F3_CSRRWI = 3'b101;
    localparam logic [11:0] CSR_TOHOST = 12'h51E;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } wb_state_e;

    function automatic logic writes_rd(input logic [6:0] op);
        return op inside {OPC_ARI_RTYPE, OPC_ARI_ITYPE, OPC_LUI,
                          OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD};
    endfunction

endpackage

// File: rtl/writeback_stage_if.sv
// Bundle of stage-2 -> writeback signals and the data-memory response.
// CSR_TOHOST_EN adds the CSR source, address and tohost value.
interface writeback_stage_if;

    logic        x_valid;
    logic [6:0]  x_opcode;
    logic [2:0]  x_funct3;
    logic [4:0]  x_rd;
    logic [31:0] x_alu;
    logic [31:0] x_pc;
`ifdef CSR_TOHOST_EN
    logic [31:0] x_rs1d;
    logic [11:0] x_csr;
    logic [31:0] csr_tohost;
`endif
    logic        dmem_resp_valid;
    logic [31:0] dmem_resp_data;
    logic        stall;
    logic [4:0]  rd_mw;
    logic        rwe_mw;
    logic [31:0] wb_data_mw;

    modport master (
        output x_valid, x_opcode, x_funct3, x_rd, x_alu, x_pc,
`ifdef CSR_TOHOST_EN
        output x_rs1d, x_csr,
        input  csr_tohost,
`endif
        output dmem_resp_valid, dmem_resp_data,
        input  stall, rd_mw, rwe_mw, wb_data_mw
    );

    modport slave (
        input  x_valid, x_opcode, x_funct3, x_rd, x_alu, x_pc,
`ifdef CSR_TOHOST_EN
        input  x_rs1d, x_csr,
        output csr_tohost,
`endif
        input  dmem_resp_valid, dmem_resp_data,
        output stall, rd_mw, rwe_mw, wb_data_mw
    );

endinterface

// File: rtl/writeback_stage_load_extend.sv
// Load data alignment and sign/zero extension (combinational).
// Halfwords pick by addr[1], bytes by addr[1:0]; unknown funct3 passes the word.
module load_extend
    import writeback_stage_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_data,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_data[7:0];
        unique case (i_addr_lo)
            2'd0: w_byte = i_data[7:0];
            2'd1: w_byte = i_data[15:8];
            2'd2: w_byte = i_data[23:16];
            2'd3: w_byte = i_data[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_data[31:16] : i_data[15:0];
    end

    always_comb begin
        o_data = i_data;
        case (i_funct3)
            F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
            F3_LBU:  o_data = {24'd0, w_byte};
            F3_LH:   o_data = {{16{w_half[15]}}, w_half};
            F3_LHU:  o_data = {16'd0, w_half};
            default: o_data = i_data;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Memory/writeback stage: MW registers, load-wait FSM, writeback mux.
// Define CSR_TOHOST_EN to add the tohost CSR (csrrw/csrrwi to 0x51E).
module writeback_stage
    import writeback_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        x_valid,
    input  logic [6:0]  x_opcode,
    input  logic [2:0]  x_funct3,
    input  logic [4:0]  x_rd,
    input  logic [31:0] x_alu,
    input  logic [31:0] x_pc,
`ifdef CSR_TOHOST_EN
    input  logic [31:0] x_rs1d,
    input  logic [11:0] x_csr,
    output logic [31:0] csr_tohost,
`endif
    input  logic        dmem_resp_valid,
    input  logic [31:0] dmem_resp_data,
    output logic        stall,
    output logic [4:0]  rd_mw,
    output logic        rwe_mw,
    output logic [31:0] wb_data_mw
);

    wb_state_e   r_state;
    logic        r_valid;
    logic [6:0]  r_opcode;
    logic [2:0]  r_funct3;
    logic [4:0]  r_rd;
    logic [31:0] r_alu;
    logic [31:0] r_pc;
    logic        w_stall;
    logic        w_cap_load;
    logic [31:0] w_ld_data;

    assign w_stall    = (r_state == ST_WAIT) && !dmem_resp_valid;
    assign w_cap_load = x_valid && (x_opcode == OPC_LOAD);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_RUN;
            r_valid  <= 1'b0;
            r_opcode <= 7'd0;
            r_funct3 <= 3'd0;
            r_rd     <= 5'd0;
            r_alu    <= 32'd0;
            r_pc     <= 32'd0;
        end else if (!w_stall) begin
            // A response edge also captures the next instruction.
            r_state  <= w_cap_load ? ST_WAIT : ST_RUN;
            r_valid  <= x_valid;
            r_opcode <= x_opcode;
            r_funct3 <= x_funct3;
            r_rd     <= x_rd;
            r_alu    <= x_alu;
            r_pc     <= x_pc;
        end
    end

`ifdef CSR_TOHOST_EN
    logic [31:0] r_tohost;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tohost <= 32'd0;
        end else if (!w_stall && x_valid && x_opcode == OPC_SYSTEM
                     && x_csr == CSR_TOHOST) begin
            if (x_funct3 == F3_CSRRW) begin
                r_tohost <= x_rs1d;
            end else if (x_funct3 == F3_CSRRWI) begin
                r_tohost <= {27'd0, x_rs1d[4:0]};
            end
        end
    end

    assign csr_tohost = r_tohost;
`endif

    load_extend u_load_extend (
        .i_funct3  (r_funct3),
        .i_addr_lo (r_alu[1:0]),
        .i_data    (dmem_resp_data),
        .o_data    (w_ld_data)
    );

    always_comb begin
        wb_data_mw = r_alu;
        if (r_opcode == OPC_JAL || r_opcode == OPC_JALR) begin
            wb_data_mw = r_pc + 32'd4;
        end else if (r_opcode == OPC_LOAD) begin
            wb_data_mw = w_ld_data;
        end
    end

    // Reset blocks the write of a load whose response arrives that cycle.
    assign rwe_mw = r_valid && writes_rd(r_opcode) && (r_rd != 5'd0)
                    && !w_stall && !reset;
    assign stall  = w_stall;
    assign rd_mw  = r_rd;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage.
// Covers reset, ALU/JAL writeback, load waits, extension and reset-in-WAIT.
module tb_writeback_stage;
    import writeback_stage_pkg::*;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    writeback_stage_if wb_if ();

    writeback_stage dut (
        .clk             (clk),
        .reset           (reset),
        .x_valid         (wb_if.x_valid),
        .x_opcode        (wb_if.x_opcode),
        .x_funct3        (wb_if.x_funct3),
        .x_rd            (wb_if.x_rd),
        .x_alu           (wb_if.x_alu),
        .x_pc            (wb_if.x_pc),
`ifdef CSR_TOHOST_EN
        .x_rs1d          (wb_if.x_rs1d),
        .x_csr           (wb_if.x_csr),
        .csr_tohost      (wb_if.csr_tohost),
`endif
        .dmem_resp_valid (wb_if.dmem_resp_valid),
        .dmem_resp_data  (wb_if.dmem_resp_data),
        .stall           (wb_if.stall),
        .rd_mw           (wb_if.rd_mw),
        .rwe_mw          (wb_if.rwe_mw),
        .wb_data_mw      (wb_if.wb_data_mw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [6:0] op, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [31:0] alu,
                         input logic [31:0] pc);
        wb_if.x_valid  = 1'b1;
        wb_if.x_opcode = op;
        wb_if.x_funct3 = f3;
        wb_if.x_rd     = rd;
        wb_if.x_alu    = alu;
        wb_if.x_pc     = pc;
    endtask

    task automatic idle();
        wb_if.x_valid  = 1'b0;
        wb_if.x_opcode = 7'd0;
        wb_if.x_rd     = 5'd0;
    endtask

    task automatic resp(input logic v, input logic [31:0] d);
        wb_if.dmem_resp_valid = v;
        wb_if.dmem_resp_data  = d;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
        n_cmp++; if (wb_if.stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b want 0", wb_if.stall); end
        n_cmp++; if (wb_if.rwe_mw !== 1'b0) begin n_err++; $display("FAIL reset_rwe got %b want 0", wb_if.rwe_mw); end
        n_cmp++; if (wb_if.wb_data_mw !== 32'h0) begin n_err++; $display("FAIL reset_wb got %h want 0", wb_if.wb_data_mw); end
        n_cmp++; if (wb_if.rd_mw !== 5'd0) begin n_err++; $display("FAIL reset_rd got %0d want 0", wb_if.rd_mw); end
    endtask

    task automatic test_alu();
        issue(OPC_ARI_ITYPE, 3'b000, 5'd5, 32'h0000_0123, 32'h100);
        step();
        idle();
        #1;
        n_cmp++; if (wb_if.rd_mw !== 5'd5) begin n_err++; $display("FAIL addi_rd got %0d want 5", wb_if.rd_mw); end
        n_cmp++; if (wb_if.rwe_mw !== 1'b1) begin n_err++; $display("FAIL addi_rwe got %b want 1", wb_if.rwe_mw); end
        n_cmp++; if (wb_if.wb_data_mw !== 32'h123) begin n_err++; $display("FAIL addi_wb got %h want 00000123", wb_if.wb_data_mw); end
        n_cmp++; if (wb_if.stall !== 1'b0) begin n_err++; $display("FAIL addi_stall got %b want 0", wb_if.stall); end
    endtask

    task automatic test_load_delayed();
        issue(OPC_LOAD, F3_LB, 5'd6, 32'h0000_1002, 32'h104);
        step();
        idle();
        for (int i = 0; i < 3; i++) begin
            resp(1'b0, 32'hDEAD_0000);
            n_cmp++; if (wb_if.stall !== 1'b1) begin n_err++; $display("FAIL lb_wait_stall[%0d] got %b want 1", i, wb_if.stall); end
            n_cmp++; if (wb_if.rwe_mw !== 1'b0) begin n_err++; $display("FAIL lb_wait_rwe[%0d] got %b want 0", i, wb_if.rwe_mw); end
            step();
        end
        resp(1'b1, 32'h0080_0000);
        n_cmp++; if (wb_if.stall !== 1'b0) begin n_err++; $display("FAIL lb_resp_stall got %b want 0", wb_if.stall); end
        n_cmp++; if (wb_if.rwe_mw !== 1'b1) begin n_err++; $display("FAIL lb_resp_rwe got %b want 1", wb_if.rwe_mw); end
        n_cmp++; if (wb_if.wb_data_mw !== 32'hFFFF_FF80) begin n_err++; $display("FAIL lb_resp_wb got %h want ffffff80", wb_if.wb_data_mw); end
        n_cmp++; if (wb_if.rd_mw !== 5'd6) begin n_err++; $display("FAIL lb_resp_rd got %0d want 6", wb_if.rd_mw); end
        step();
        resp(1'b1, 32'h0000_0000);
        n_cmp++; if (wb_if.stall !== 1'b0) begin n_err++; $display("FAIL lb_after_stall got %b want 0", wb_if.stall); end
        n_cmp++; if (wb_if.rwe_mw !== 1'b0) begin n_err++; $display("FAIL lb_after_rwe got %b want 0", wb_if.rwe_mw); end
        resp(1'b0, 32'h0);
    endtask

    task automatic test_load_ext();
        logic [2:0]  f3  [5];
        logic [31:0] adr [5];
        logic [31:0] dat [5];
        logic [31:0] exp [5];
        f3[0] = F3_LHU; adr[0] = 32'h2; dat[0] = 32'hBEEF_1234; exp[0] = 32'h0000_BEEF;
        f3[1] = F3_LH;  adr[1] = 32'h0; dat[1] = 32'h1234_8001; exp[1] = 32'hFFFF_8001;
        f3[2] = F3_LBU; adr[2] = 32'h3; dat[2] = 32'hAB00_0000; exp[2] = 32'h0000_00AB;
        f3[3] = F3_LW;  adr[3] = 32'h3; dat[3] = 32'hDEAD_BEEF; exp[3] = 32'hDEAD_BEEF;
        f3[4] = F3_LH;  adr[4] = 32'h3; dat[4] = 32'h7FFF_0000; exp[4] = 32'h0000_7FFF;
        for (int i = 0; i < 5; i++) begin
            issue(OPC_LOAD, f3[i], 5'd10, adr[i], 32'h200);
            step();
            idle();
            resp(1'b1, dat[i]);
            n_cmp++; if (wb_if.stall !== 1'b0) begin n_err++; $display("FAIL ld_same_stall[%0d] got %b want 0", i, wb_if.stall); end
            n_cmp++; if (wb_if.wb_data_mw !== exp[i]) begin n_err++; $display("FAIL ld_ext_wb[%0d] got %h want %h", i, wb_if.wb_data_mw, exp[i]); end
            n_cmp++; if (wb_if.rwe_mw !== 1'b1) begin n_err++; $display("FAIL ld_same_rwe[%0d] got %b want 1", i, wb_if.rwe_mw); end
            step();
            resp(1'b0, 32'h0);
        end
    endtask

    task automatic test_jal_x0();
        issue(OPC_JAL, 3'b000, 5'd1, 32'h1234_5678, 32'hFFFF_FFFC);
        step();
        issue(OPC_ARI_ITYPE, 3'b000, 5'd0, 32'h0000_0005, 32'h0);
        #1;
        n_cmp++; if (wb_if.wb_data_mw !== 32'h0) begin n_err++; $display("FAIL jal_wrap_wb got %h want 0", wb_if.wb_data_mw); end
        n_cmp++; if (wb_if.rwe_mw !== 1'b1) begin n_err++; $display("FAIL jal_rwe got %b want 1", wb_if.rwe_mw); end
        step();
        idle();
        #1;
        n_cmp++; if (wb_if.rwe_mw !== 1'b0) begin n_err++; $display("FAIL addi_x0_rwe got %b want 0", wb_if.rwe_mw); end
        n_cmp++; if (wb_if.wb_data_mw !== 32'h5) begin n_err++; $display("FAIL addi_x0_wb got %h want 5", wb_if.wb_data_mw); end
    endtask

    task automatic test_back_to_back();
        issue(OPC_LOAD, F3_LW, 5'd8, 32'h0000_0010, 32'h300);
        step();
        issue(OPC_ARI_RTYPE, 3'b000, 5'd9, 32'h0000_0055, 32'h304);
        resp(1'b0, 32'h0);
        n_cmp++; if (wb_if.stall !== 1'b1) begin n_err++; $display("FAIL b2b_stall got %b want 1", wb_if.stall); end
        step();
        resp(1'b1, 32'hCAFE_F00D);
        n_cmp++; if (wb_if.wb_data_mw !== 32'hCAFE_F00D) begin n_err++; $display("FAIL b2b_ld_wb got %h want cafef00d", wb_if.wb_data_mw); end
        step();
        idle();
        resp(1'b0, 32'h0);
        n_cmp++; if (wb_if.rd_mw !== 5'd9) begin n_err++; $display("FAIL b2b_add_rd got %0d want 9", wb_if.rd_mw); end
        n_cmp++; if (wb_if.wb_data_mw !== 32'h55) begin n_err++; $display("FAIL b2b_add_wb got %h want 55", wb_if.wb_data_mw); end
        n_cmp++; if (wb_if.rwe_mw !== 1'b1) begin n_err++; $display("FAIL b2b_add_rwe got %b want 1", wb_if.rwe_mw); end
        step();
    endtask

    task automatic test_reset_wait();
        issue(OPC_LOAD, F3_LW, 5'd7, 32'h0000_0020, 32'h400);
        step();
        idle();
        reset = 1'b1;
        resp(1'b1, 32'h1111_2222);
        n_cmp++; if (wb_if.rwe_mw !== 1'b0) begin n_err++; $display("FAIL rstwait_rwe got %b want 0", wb_if.rwe_mw); end
        step();
        reset = 1'b0;
        resp(1'b0, 32'h0);
        n_cmp++; if (wb_if.stall !== 1'b0) begin n_err++; $display("FAIL rstwait_stall got %b want 0", wb_if.stall); end
        n_cmp++; if (wb_if.rwe_mw !== 1'b0) begin n_err++; $display("FAIL rstwait_rwe2 got %b want 0", wb_if.rwe_mw); end
        step();
        resp(1'b1, 32'h3333_4444);
        n_cmp++; if (wb_if.rwe_mw !== 1'b0) begin n_err++; $display("FAIL late_resp_rwe got %b want 0", wb_if.rwe_mw); end
        n_cmp++; if (wb_if.stall !== 1'b0) begin n_err++; $display("FAIL late_resp_stall got %b want 0", wb_if.stall); end
        step();
        resp(1'b0, 32'h0);
    endtask

`ifdef CSR_TOHOST_EN
    task automatic test_csr();
        n_cmp++; if (wb_if.csr_tohost !== 32'h0) begin n_err++; $display("FAIL tohost_reset got %h want 0", wb_if.csr_tohost); end
        issue(OPC_SYSTEM, F3_CSRRW, 5'd3, 32'h0, 32'h500);
        wb_if.x_rs1d = 32'h1;
        wb_if.x_csr  = CSR_TOHOST;
        step();
        idle();
        #1;
        n_cmp++; if (wb_if.csr_tohost !== 32'h1) begin n_err++; $display("FAIL tohost_val got %h want 1", wb_if.csr_tohost); end
        n_cmp++; if (wb_if.rwe_mw !== 1'b0) begin n_err++; $display("FAIL tohost_rwe got %b want 0", wb_if.rwe_mw); end
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        wb_if.x_funct3 = 3'd0;
        wb_if.x_alu    = 32'd0;
        wb_if.x_pc     = 32'd0;
`ifdef CSR_TOHOST_EN
        wb_if.x_rs1d = 32'd0;
        wb_if.x_csr  = 12'd0;
`endif
        idle();
        wb_if.dmem_resp_valid = 1'b0;
        wb_if.dmem_resp_data  = 32'd0;
        test_reset();
`ifdef CSR_TOHOST_EN
        test_csr();
`endif
        test_alu();
        test_load_delayed();
        test_load_ext();
        test_jal_x0();
        test_back_to_back();
        test_reset_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state updates on the rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: x_valid  input  1  stage-2 instruction valid this cycle.
REQ-004 SHALL have ports: x_opcode  input  7 and x_funct3  input  3, the stage-2 instruction fields.
REQ-005 SHALL have port: x_rd  input  5  destination register index.
REQ-006 SHALL have ports: x_alu  input  32  ALU result/memory address; x_pc  input  32  instruction PC.
REQ-007 SHALL have port: x_rs1d  input  32  forwarded rs1 data, CSR source (CSR_TOHOST_EN only).
REQ-008 SHALL have port: x_csr  input  12  CSR address (CSR_TOHOST_EN only).
REQ-009 SHALL have ports: dmem_resp_valid  input  1 and dmem_resp_data  input  32, the data-memory read response.
REQ-010 SHALL have port: stall  output  1  freezes stages 1-2 and holds x_* inputs.
REQ-011 SHALL have ports: rd_mw  output  5, rwe_mw  output  1 and wb_data_mw  output  32, driving RegFile write and stage-2 forwarding.
REQ-012 SHALL have port: csr_tohost  output  32  tohost CSR value (CSR_TOHOST_EN only).

Function
REQ-013 SHALL capture x_* into MW registers and set mw_valid<=x_valid on each edge where stall=0; hold all MW registers when stall=1.
REQ-014 SHALL implement two-state FSM RUN/WAIT: RUN->WAIT on capture of a valid LOAD; WAIT->RUN on the edge where dmem_resp_valid=1.
REQ-015 SHALL drive stall = (state==WAIT) && !dmem_resp_valid, so a same-cycle response releases the pipeline in that cycle.
REQ-016 SHALL ignore dmem_resp_valid in RUN.
REQ-017 SHALL assert rwe_mw = mw_valid && opcode in {ARI_RTYPE, ARI_ITYPE, LUI, AUIPC, JAL, JALR, LOAD} && rd_mw!=0 && !(state==WAIT && !dmem_resp_valid).
REQ-018 SHALL select wb_data_mw: JAL/JALR -> pc+4 (mod 2^32); LOAD -> extended load data; all others -> alu.
REQ-019 SHALL extend load data: LW whole word, alu[1:0] ignored; LH/LHU halfword at alu[1] (alu[0] ignored); LB/LBU byte at alu[1:0]; LB/LH sign-extend, LBU/LHU zero-extend; other funct3 -> whole word.
REQ-020 SHALL present non-load writeback exactly one cycle after capture; load writeback in the cycle dmem_resp_valid is first seen in WAIT.
REQ-021 SHALL drive rd_mw from the MW register whether or not rwe_mw is asserted.

Reset
REQ-022 SHALL on reset set state=RUN, mw_valid=0 and MW opcode to 0, so stall=0, rwe_mw=0 and wb_data_mw=0.
REQ-023 SHALL on reset in WAIT abandon the pending load with no writeback, even if dmem_resp_valid is high that cycle.
REQ-024 SHALL set csr_tohost=0 on reset.

Configuration
REQ-025 SHALL with CSR_TOHOST_EN defined load csr_tohost<=rs1d on a captured valid SYSTEM instruction with funct3=001 (csrrw) and csr=0x51E, or zero-extended rs1-field immediate for funct3=101 (csrrwi), with no GPR write.
REQ-026 SHALL with CSR_TOHOST_EN undefined omit x_rs1d, x_csr and csr_tohost ports and the tohost register, treating SYSTEM as non-writing.

Structure
REQ-027 SHALL take opcode constants from the shared Opcode.vh and put load funct3 codes, the CSR_TOHOST address and FSM encodings in the shared package/header.
REQ-028 SHALL put REQ-019 in one combinational sub-module named load_extend.

Verification
REQ-029 SHALL cover: ADDI x5 with alu=0x0000_0123 -> next cycle rd_mw=5, rwe_mw=1, wb_data_mw=0x123, stall=0.
REQ-030 SHALL cover: LB x6 with alu=0x...02 and resp 0x0080_0000 delayed 3 cycles -> stall=1 for 3 cycles, then wb_data_mw=0xFFFF_FF80, rwe_mw=1.
REQ-031 SHALL cover: LHU alu=0x...02, resp 0xBEEF_1234 same cycle as entry to WAIT -> stall=0, wb_data_mw=0x0000_BEEF.
REQ-032 SHALL cover: JAL x1 pc=0xFFFF_FFFC -> wb_data_mw=0x0000_0000; ADDI x0 -> rwe_mw=0.
REQ-033 SHALL cover: reset asserted in WAIT with dmem_resp_valid=1 -> next cycle stall=0, rwe_mw=0; later response ignored.
REQ-034 SHALL cover (CSR_TOHOST_EN): csrw 0x51E with rs1d=0x1 -> csr_tohost=0x1 one cycle after capture, rwe_mw=0.
